// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply controller and memories.
package matmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_OUTPUT = 3'd3,
    S_DONE   = 3'd4
  } ctrl_state_t;

  // Never return a zero width, even for degenerate 1-entry memories.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int K_BITS(input int maxk);
    return clog2_min1(maxk + 1);
  endfunction

  function automatic int A_ADDR_BITS(input int m, input int maxk);
    return clog2_min1(m * maxk);
  endfunction

  function automatic int B_ADDR_BITS(input int maxk, input int n);
    return clog2_min1(maxk * n);
  endfunction

endpackage

// File: rtl/compute_ctrl_idx_counter.sv
// Wrapping index counter with runtime limit, enable, sync clear and async reset.
module idx_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = (cnt == limit - W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/compute_ctrl.sv
// Sequencer for an output-stationary matmul: issues A/B reads, drives the MAC, hands off C.
// Optional stall counter port enabled by defining COMPUTE_CTRL_PERF_EN.
module compute_ctrl
  import matmul_pkg::*;
#(
  parameter int M       = 7,
  parameter int N       = 9,
  parameter int MAXK    = 8,
  parameter int MAC_LAT = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                matrices_loaded,
  input  logic [K_BITS(MAXK)-1:0]             K,
  output logic [A_ADDR_BITS(M, MAXK)-1:0]     A_read_addr,
  output logic [B_ADDR_BITS(MAXK, N)-1:0]     B_read_addr,
  output logic                                mac_en,
  output logic                                mac_clear,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                compute_finished
`ifdef COMPUTE_CTRL_PERF_EN
  ,
  output logic [31:0]                         stall_cycles
`endif
);

  localparam int KW = K_BITS(MAXK);
  localparam int AW = A_ADDR_BITS(M, MAXK);
  localparam int BW = B_ADDR_BITS(MAXK, N);
  localparam int IW = $clog2(M + 1);
  localparam int JW = $clog2(N + 1);
  localparam int DW = $clog2(MAC_LAT + 2);

  ctrl_state_t   state;
  logic [KW-1:0] k_lat;
  logic [DW-1:0] drain_cnt;
  logic          armed;

  logic [IW-1:0] i_cnt;
  logic [JW-1:0] j_cnt;
  logic [KW-1:0] k_cnt;
  logic          i_wrap;
  logic          j_wrap;
  logic          k_wrap;

  logic          issue;
  logic          start;
  logic          xfer;

  assign issue     = (state == S_ISSUE);
  assign start     = (state == S_IDLE) && matrices_loaded && armed;
  assign xfer      = (state == S_OUTPUT) && out_ready;
  assign out_valid = (state == S_OUTPUT);

  idx_counter #(.W(IW)) u_i (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (xfer && j_wrap),
    .limit (IW'(M)),
    .cnt   (i_cnt),
    .wrap  (i_wrap)
  );

  idx_counter #(.W(JW)) u_j (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (xfer),
    .limit (JW'(N)),
    .cnt   (j_cnt),
    .wrap  (j_wrap)
  );

  idx_counter #(.W(KW)) u_k (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (issue),
    .limit (k_lat),
    .cnt   (k_cnt),
    .wrap  (k_wrap)
  );

  assign A_read_addr = issue
    ? AW'(i_cnt) * AW'(k_lat) + AW'(k_cnt)
    : '0;

  assign B_read_addr = issue
    ? BW'(k_cnt) * BW'(N) + BW'(j_cnt)
    : '0;

  // armed blocks a re-run until matrices_loaded is seen low in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      k_lat            <= '0;
      drain_cnt        <= '0;
      armed            <= 1'b1;
      mac_en           <= 1'b0;
      mac_clear        <= 1'b0;
      compute_finished <= 1'b0;
    end else begin
      mac_en           <= issue;
      mac_clear        <= issue && (k_cnt == '0);
      compute_finished <= (state == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (!matrices_loaded) begin
            armed <= 1'b1;
          end else if (armed) begin
            if (K != '0) begin
              state <= S_ISSUE;
              k_lat <= K;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (k_wrap) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(MAC_LAT)) begin
            state <= S_OUTPUT;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            state <= (i_wrap && j_wrap) ? S_DONE : S_ISSUE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          armed <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef COMPUTE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (start && (K != '0)) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
